jtag_tap: RTL and testbench
===========================

JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1102_1CDF, meaning the 32-bit value loaded into the IDCODE data register. The default is version 1, part 0x1021, lowRISC JEDEC ID and fixed LSB 1.
REQ-002 SHALL have parameter IR_WIDTH, default 5, meaning the instruction register width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single system clock. All state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port tck_i, input, 1 bit: JTAG TCK, already synchronised to clk_i, oversampled.
REQ-006 SHALL have port tms_i, input, 1 bit: JTAG TMS, synchronised.
REQ-007 SHALL have port tdi_i, input, 1 bit: JTAG TDI, synchronised.
REQ-008 SHALL have port tdo_o, output, 1 bit: JTAG TDO.
REQ-009 SHALL have port tdo_oe_o, output, 1 bit: TDO output enable.
REQ-010 SHALL have port ir_o, output, IR_WIDTH bits: current instruction.
REQ-011 SHALL have port capture_dr_o, output, 1 bit: external DR capture strobe.
REQ-012 SHALL have port shift_dr_o, output, 1 bit: external DR shift strobe.
REQ-013 SHALL have port update_dr_o, output, 1 bit: external DR update strobe.
REQ-014 SHALL have port ext_tdo_i, input, 1 bit: serial output of the external DR.

Function
REQ-015 SHALL register tck_i as tck_q. rise = tck_i & !tck_q; fall = !tck_i & tck_q. Both are one clk_i cycle wide.
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM:
  - States: TestLogicReset, RunTestIdle, SelectDR, CaptureDR, ShiftDR, Exit1DR, PauseDR, Exit2DR, UpdateDR, SelectIR, CaptureIR, ShiftIR, Exit1IR, PauseIR, Exit2IR, UpdateIR.
  - Transitions use standard TMS encoding.
  - The FSM advances only on rise.
REQ-017 SHALL execute each state action on the rise that leaves that state:
  - CaptureIR: ir_shift <= 5'b00001.
  - ShiftIR: ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]}.
  - UpdateIR: ir_q <= ir_shift.
REQ-018 SHALL force ir_q to 5'h01 (IDCODE) on every rise while in TestLogicReset.
REQ-019 SHALL decode ir_q as follows:
  - 5'h01: IDCODE DR.
  - 5'h10 and 5'h11: external DR.
  - All other values, including 5'h00 and 5'h1F: BYPASS DR.
REQ-020 SHALL handle the IDCODE DR as follows:
  - CaptureDR loads IDCODE.
  - ShiftDR does id_shift <= {tdi_i, id_shift[31:1]}.
  - UpdateDR has no effect.
REQ-021 SHALL handle the BYPASS DR as follows: CaptureDR loads 0; ShiftDR loads tdi_i.
REQ-022 SHALL pulse capture_dr_o, shift_dr_o and update_dr_o high for exactly the rise cycle when the FSM is in CaptureDR, ShiftDR or UpdateDR respectively and ir_q is an external code; otherwise each is 0.
REQ-023 SHALL update tdo_o and tdo_oe_o only on fall:
  - In ShiftIR: tdo_o = ir_shift[0].
  - In ShiftDR: tdo_o = LSB of the selected DR, or ext_tdo_i for external codes.
  - tdo_oe_o = 1 in ShiftIR and ShiftDR, else 0.
  - tdo_o = 0 when tdo_oe_o = 0.
REQ-024 SHALL require 5 consecutive rises with tms_i = 1 to reach TestLogicReset from any state.
REQ-025 SHALL ignore rise or fall when tck_i toggles and rst_i is asserted in the same cycle: reset wins.
REQ-026 SHALL produce no TAP activity while tck_i is static, regardless of tms_i and tdi_i.

Reset
REQ-027 SHALL on rst_i = 1 set state = TestLogicReset, ir_q = 5'h01, ir_shift = 0, id_shift = 0, bypass = 0, tck_q = 0, tdo_o = 0, tdo_oe_o = 0 and all strobes 0, effective at the next clk_i edge.
REQ-028 SHALL apply reset mid-shift immediately, discarding partial shift contents.

Verification
REQ-029 SHALL cover IDCODE readout: reset, then TMS 0,1,0,0, then 32 ShiftDR TCK cycles with TDI = 0. TDO bits, LSB first, must equal 0x11021CDF.
REQ-030 SHALL cover IR capture: go to ShiftIR and shift 5 bits. TDO must read 1,0,0,0,0.
REQ-031 SHALL cover BYPASS: load IR 0x1F, then shift pattern 1011 in ShiftDR. TDO must read 0,1,0,1 (captured 0 first, then TDI delayed by one bit).
REQ-032 SHALL cover the external DR: load IR 0x11, then do a capture, 8 shifts and an update.
  - Must see exactly 1, 8 and 1 single-cycle pulses on capture_dr_o, shift_dr_o and update_dr_o.
  - tdo_o must follow ext_tdo_i at each fall.
REQ-033 SHALL cover TMS reset: from PauseDR with IR = 0x1F, apply 5 rises with TMS = 1. The FSM must be in TestLogicReset and ir_o must be 5'h01.
REQ-034 SHALL cover reset mid-operation: assert rst_i after 10 IDCODE shifts. tdo_oe_o = 0 next cycle; a fresh IDCODE read must again return 0x11021CDF.

Source files
------------

// File: rtl/jtag_tap.sv
// JTAG TAP controller that runs on the system clock and oversamples a pre-synchronised TCK.
// It has IDCODE and BYPASS data registers and strobes for one external data register.
module jtag_tap #(
    parameter logic [31:0] IDCODE   = 32'h1102_1CDF,
    parameter int unsigned IR_WIDTH = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic                capture_dr_o,
    output logic                shift_dr_o,
    output logic                update_dr_o,
    input  logic                ext_tdo_i
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_EXT0   = IR_WIDTH'(5'h10);
    localparam logic [IR_WIDTH-1:0] IR_EXT1   = IR_WIDTH'(5'h11);

    tap_state_e          r_state;
    tap_state_e          w_next;
    logic                r_tck_q;
    logic [IR_WIDTH-1:0] r_ir_q;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [31:0]         r_id_shift;
    logic                r_bypass;
    logic                r_tdo;
    logic                r_tdo_oe;
    logic                r_capture_dr;
    logic                r_shift_dr;
    logic                r_update_dr;

    logic w_rise;
    logic w_fall;
    logic w_sel_id;
    logic w_sel_ext;
    logic w_dr_tdo;

    assign w_rise    = tck_i & ~r_tck_q;
    assign w_fall    = ~tck_i & r_tck_q;
    assign w_sel_id  = (r_ir_q == IR_IDCODE);
    assign w_sel_ext = (r_ir_q == IR_EXT0) || (r_ir_q == IR_EXT1);
    assign w_dr_tdo  = w_sel_ext ? ext_tdo_i : (w_sel_id ? r_id_shift[0] : r_bypass);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            TEST_LOGIC_RESET: w_next = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_next = tms_i ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        w_next = tms_i ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       w_next = tms_i ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         w_next = tms_i ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         w_next = tms_i ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         w_next = tms_i ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         w_next = tms_i ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        w_next = tms_i ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        w_next = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_next = tms_i ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         w_next = tms_i ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         w_next = tms_i ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         w_next = tms_i ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         w_next = tms_i ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        w_next = tms_i ? SELECT_DR : RUN_TEST_IDLE;
            default:          w_next = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= TEST_LOGIC_RESET;
            r_tck_q      <= 1'b0;
            r_ir_q       <= IR_IDCODE;
            r_ir_shift   <= '0;
            r_id_shift   <= '0;
            r_bypass     <= 1'b0;
            r_tdo        <= 1'b0;
            r_tdo_oe     <= 1'b0;
            r_capture_dr <= 1'b0;
            r_shift_dr   <= 1'b0;
            r_update_dr  <= 1'b0;
        end else begin
            r_tck_q      <= tck_i;
            r_capture_dr <= 1'b0;
            r_shift_dr   <= 1'b0;
            r_update_dr  <= 1'b0;
            if (w_rise) begin
                r_state <= w_next;
                case (r_state)
                    TEST_LOGIC_RESET: r_ir_q <= IR_IDCODE;
                    CAPTURE_IR:       r_ir_shift <= IR_WIDTH'(1);
                    SHIFT_IR:         r_ir_shift <= {tdi_i, r_ir_shift[IR_WIDTH-1:1]};
                    UPDATE_IR:        r_ir_q <= r_ir_shift;
                    CAPTURE_DR: begin
                        if (w_sel_id) r_id_shift <= IDCODE;
                        else if (!w_sel_ext) r_bypass <= 1'b0;
                        r_capture_dr <= w_sel_ext;
                    end
                    SHIFT_DR: begin
                        if (w_sel_id) r_id_shift <= {tdi_i, r_id_shift[31:1]};
                        else if (!w_sel_ext) r_bypass <= tdi_i;
                        r_shift_dr <= w_sel_ext;
                    end
                    UPDATE_DR:        r_update_dr <= w_sel_ext;
                    default: ;
                endcase
                // Entering reset also selects IDCODE, so ir_o reads IDCODE as soon as the TAP lands there.
                if (w_next == TEST_LOGIC_RESET) r_ir_q <= IR_IDCODE;
            end
            if (w_fall) begin
                case (r_state)
                    SHIFT_IR: begin
                        r_tdo    <= r_ir_shift[0];
                        r_tdo_oe <= 1'b1;
                    end
                    SHIFT_DR: begin
                        r_tdo    <= w_dr_tdo;
                        r_tdo_oe <= 1'b1;
                    end
                    default: begin
                        r_tdo    <= 1'b0;
                        r_tdo_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tdo_o        = r_tdo;
    assign tdo_oe_o     = r_tdo_oe;
    assign ir_o         = r_ir_q;
    assign capture_dr_o = r_capture_dr;
    assign shift_dr_o   = r_shift_dr;
    assign update_dr_o  = r_update_dr;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: IDCODE, IR capture, BYPASS, external DR, TMS reset and mid-shift reset.
module tb_jtag_tap;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tck_i = 1'b0;
    logic       tms_i = 1'b0;
    logic       tdi_i = 1'b0;
    logic       ext_tdo_i = 1'b0;
    logic       tdo_o;
    logic       tdo_oe_o;
    logic [4:0] ir_o;
    logic       capture_dr_o;
    logic       shift_dr_o;
    logic       update_dr_o;

    int n_checks = 0;
    int n_err    = 0;

    int cap_hi = 0, shf_hi = 0, upd_hi = 0;
    int cap_ed = 0, shf_ed = 0, upd_ed = 0;
    logic cap_d = 1'b0, shf_d = 1'b0, upd_d = 1'b0;

    jtag_tap #(.IDCODE(32'h1102_1CDF), .IR_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .ir_o(ir_o),
        .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o),
        .ext_tdo_i(ext_tdo_i)
    );

    always #5 clk_i = ~clk_i;

    // Strobe monitor: cycles high and rising edges, so pulse width can be verified.
    always @(posedge clk_i) begin
        cap_d <= capture_dr_o;
        shf_d <= shift_dr_o;
        upd_d <= update_dr_o;
        if (capture_dr_o) cap_hi <= cap_hi + 1;
        if (shift_dr_o)   shf_hi <= shf_hi + 1;
        if (update_dr_o)  upd_hi <= upd_hi + 1;
        if (capture_dr_o && !cap_d) cap_ed <= cap_ed + 1;
        if (shift_dr_o && !shf_d)   shf_ed <= shf_ed + 1;
        if (update_dr_o && !upd_d)  upd_ed <= upd_ed + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One full TCK period; tdo_o afterwards holds the value launched on this fall.
    task automatic tick(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        tck_i = 1'b1;
        clks(3);
        tck_i = 1'b0;
        clks(3);
    endtask

    // From RunTestIdle: shift val into IR (LSB first), collect TDO, finish in RunTestIdle.
    task automatic shift_ir(input logic [4:0] val, output logic [4:0] seen);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        seen[0] = tdo_o;
        for (int i = 0; i < 4; i++) begin
            tick(0, val[i]);
            seen[i+1] = tdo_o;
        end
        tick(1, val[4]);
        tick(1, 0);
        tick(0, 0);
    endtask

    // From RunTestIdle: read the full 32-bit IDCODE DR with TDI = 0.
    task automatic read_id(output logic [31:0] w);
        tick(1, 0); tick(0, 0); tick(0, 0);
        w[0] = tdo_o;
        for (int i = 1; i < 32; i++) begin
            tick(0, 0);
            w[i] = tdo_o;
        end
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        logic [31:0] word;
        logic [4:0]  irs;
        logic [3:0]  bp;
        logic [7:0]  pat;
        logic [7:0]  got;
        logic [3:0]  st;
        int c0, s0, u0, ce0, se0, ue0;

        clks(3);
        rst_i = 1'b0;
        clks(1);
        st = dut.r_state;
        check("reset_state", 32'(st), 32'd0);
        check("reset_ir", 32'(ir_o), 32'h01);
        check("reset_tdo", 32'({tdo_o, tdo_oe_o}), 32'd0);
        check("reset_strobes", 32'({capture_dr_o, shift_dr_o, update_dr_o}), 32'd0);

        // Static TCK: TMS/TDI activity must not move the TAP.
        for (int i = 0; i < 12; i++) begin
            tms_i = i[0];
            tdi_i = i[1];
            clks(1);
        end
        st = dut.r_state;
        check("static_tck_state", 32'(st), 32'd0);

        tick(0, 0);
        read_id(word);
        check("idcode_read", word, 32'h1102_1CDF);
        check("idcode_oe_after", 32'(tdo_oe_o), 32'd0);

        shift_ir(5'h1F, irs);
        check("ir_capture", 32'(irs), 32'b00001);
        check("ir_load_1f", 32'(ir_o), 32'h1F);

        // BYPASS with TDI pattern 1,0,1,1.
        tick(1, 0); tick(0, 0); tick(0, 0);
        bp[0] = tdo_o;
        check("bypass_oe", 32'(tdo_oe_o), 32'd1);
        tick(0, 1); bp[1] = tdo_o;
        tick(0, 0); bp[2] = tdo_o;
        tick(0, 1); bp[3] = tdo_o;
        tick(1, 1); tick(1, 0); tick(0, 0);
        check("bypass_tdo", 32'(bp), 32'b1010);

        shift_ir(5'h11, irs);
        check("ir_load_11", 32'(ir_o), 32'h11);
        c0 = cap_hi; s0 = shf_hi; u0 = upd_hi;
        ce0 = cap_ed; se0 = shf_ed; ue0 = upd_ed;
        pat = 8'b1011_0010;
        tick(1, 0); ext_tdo_i = pat[0]; tick(0, 0); tick(0, 0);
        got[0] = tdo_o;
        for (int i = 1; i < 8; i++) begin
            ext_tdo_i = pat[i];
            tick(0, 0);
            got[i] = tdo_o;
        end
        ext_tdo_i = 1'b0;
        tick(1, 0); tick(1, 0); tick(0, 0);
        clks(2);
        check("ext_tdo", 32'(got), 32'(pat));
        check("ext_capture", {16'(cap_hi - c0), 16'(cap_ed - ce0)}, {16'd1, 16'd1});
        check("ext_shift",   {16'(shf_hi - s0), 16'(shf_ed - se0)}, {16'd8, 16'd8});
        check("ext_update",  {16'(upd_hi - u0), 16'(upd_ed - ue0)}, {16'd1, 16'd1});

        // TMS reset from PauseDR with IR = 0x1F.
        shift_ir(5'h1F, irs);
        tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
        st = dut.r_state;
        check("pause_dr_state", 32'(st), 32'd6);
        for (int i = 0; i < 5; i++) tick(1, 0);
        st = dut.r_state;
        check("tms_reset_state", 32'(st), 32'd0);
        check("tms_reset_ir", 32'(ir_o), 32'h01);

        // Reset during an IDCODE shift.
        tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        word = '0;
        word[0] = tdo_o;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0);
            word[i] = tdo_o;
        end
        check("partial_id", 32'(word[10:0]), 32'h4DF);
        rst_i = 1'b1;
        clks(1);
        check("midreset_oe", 32'(tdo_oe_o), 32'd0);
        st = dut.r_state;
        check("midreset_state", 32'(st), 32'd0);

        // A TCK rise while reset is held must be ignored.
        tms_i = 1'b0;
        tck_i = 1'b1;
        clks(2);
        tck_i = 1'b0;
        clks(2);
        rst_i = 1'b0;
        clks(2);
        st = dut.r_state;
        check("rise_under_reset", 32'(st), 32'd0);

        tick(0, 0);
        read_id(word);
        check("idcode_after_reset", word, 32'h1102_1CDF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
